// File: rtl/fifo_mw_mr.sv
// Bounded multi-write/multi-read circular FIFO with back-pressure, consume-on-read
// semantics, registered occupancy and sticky protocol-violation flags.
module fifo_mw_mr #(
  parameter int M          = 3,
  parameter int N          = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                               clk,
  input  logic                               arst_n,
  output logic [M-1:0]                       full_n,
  input  logic [M-1:0]                       write,
  input  logic [M-1:0][DATA_WIDTH-1:0]       din,
  output logic [N-1:0]                       empty_n,
  input  logic [N-1:0]                       read,
  output logic [N-1:0][DATA_WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH+1)-1:0]         count,
  output logic [2:0]                         err,
  input  logic                               err_clr
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SUM_W = CNT_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  ptr_t                  rd_ptr_q, rd_ptr_d;
  ptr_t                  wr_ptr_q, wr_ptr_d;
  cnt_t                  count_q, count_d;
  logic [2:0]            err_q, err_d;

  cnt_t                  free;
  cnt_t                  push_cnt;
  cnt_t                  pop_cnt;
  logic [2:0]            viol;
  logic                  run;

  // Offsets never exceed DEPTH, so one conditional subtract wraps any DEPTH.
  function automatic ptr_t wrap_add(input ptr_t ptr, input cnt_t k);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(ptr) + SUM_W'(k);
    if (sum >= SUM_W'(DEPTH)) sum = sum - SUM_W'(DEPTH);
    return sum[PTR_W-1:0];
  endfunction

  assign free  = cnt_t'(DEPTH) - count_q;
  assign count = count_q;
  assign err   = err_q;

  always_comb begin
    full_n  = '0;
    empty_n = '0;
    dout    = '0;
    for (int i = 0; i < M; i++) full_n[i] = (int'(free) >= i + 1);
    for (int j = 0; j < N; j++) begin
      empty_n[j] = (int'(count_q) >= j + 1);
      if (empty_n[j]) dout[j] = mem_q[wrap_add(rd_ptr_q, cnt_t'(j))];
    end
  end

  // Accepted writes pack densely from wr_ptr in port order; pops take only the
  // contiguous run of valid requests starting at port 0.
  always_comb begin
    mem_d    = mem_q;
    push_cnt = '0;
    pop_cnt  = '0;
    viol     = '0;
    run      = 1'b1;
    for (int i = 0; i < M; i++) begin
      if (write[i] && full_n[i]) begin
        mem_d[wrap_add(wr_ptr_q, push_cnt)] = din[i];
        push_cnt = push_cnt + cnt_t'(1);
      end
      if (write[i] && !full_n[i]) viol[0] = 1'b1;
    end
    for (int j = 0; j < N; j++) begin
      run = run & read[j] & empty_n[j];
      if (run) pop_cnt = pop_cnt + cnt_t'(1);
      if (read[j] && !empty_n[j]) viol[1] = 1'b1;
    end
    for (int j = 1; j < N; j++) begin
      if (read[j] && !read[j-1]) viol[2] = 1'b1;
    end
    rd_ptr_d = wrap_add(rd_ptr_q, pop_cnt);
    wr_ptr_d = wrap_add(wr_ptr_q, push_cnt);
    count_d  = count_q + push_cnt - pop_cnt;
    err_d    = (err_clr ? 3'b000 : err_q) | viol;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: count_q gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifndef SYNTHESIS
  int unsigned wr_xfers [M];
  int unsigned rd_xfers [N];
  int unsigned cycles;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cycles <= 0;
      for (int i = 0; i < M; i++) wr_xfers[i] <= 0;
      for (int j = 0; j < N; j++) rd_xfers[j] <= 0;
    end else begin
      cycles <= cycles + 1;
      for (int i = 0; i < M; i++) begin
        if (write[i] && full_n[i]) wr_xfers[i] <= wr_xfers[i] + 1;
      end
      for (int j = 0; j < N; j++) begin
        if (int'(pop_cnt) > j) rd_xfers[j] <= rd_xfers[j] + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst_n) begin
      assert (count_q <= cnt_t'(DEPTH))
        else $error("[%m]: occupancy %0d exceeds DEPTH %0d", count_q, DEPTH);
    end
  end

  final begin
    for (int i = 0; i < M; i++)
      $display("[%m]: write port %0d %0d/%0d", i, wr_xfers[i], cycles);
    for (int j = 0; j < N; j++)
      $display("[%m]: read port %0d %0d/%0d", j, rd_xfers[j], cycles);
  end
`endif

endmodule

// File: tb/tb_fifo_mw_mr.sv
// Directed bench for fifo_mw_mr: an M=3/N=2/DEPTH=8 instance for port behaviour
// and a DEPTH=6 instance for pointer wrap.
module tb_fifo_mw_mr;
  localparam int DW = 32;

  logic clk    = 1'b0;
  logic arst_n = 1'b1;

  always #5 clk = ~clk;

  logic [2:0]          full_n_a, write_a;
  logic [2:0][DW-1:0]  din_a;
  logic [1:0]          empty_n_a, read_a;
  logic [1:0][DW-1:0]  dout_a;
  logic [3:0]          count_a;
  logic [2:0]          err_a;
  logic                err_clr_a;

  logic [2:0]          full_n_b, write_b;
  logic [2:0][DW-1:0]  din_b;
  logic [1:0]          empty_n_b, read_b;
  logic [1:0][DW-1:0]  dout_b;
  logic [2:0]          count_b;
  logic [2:0]          err_b;
  logic                err_clr_b;

  int checks = 0;
  int errors = 0;
  int rd_idx = 0;

  fifo_mw_mr #(.M(3), .N(2), .DATA_WIDTH(DW), .DEPTH(8)) u_dut_a (
    .clk(clk), .arst_n(arst_n), .full_n(full_n_a), .write(write_a), .din(din_a),
    .empty_n(empty_n_a), .read(read_a), .dout(dout_a), .count(count_a),
    .err(err_a), .err_clr(err_clr_a)
  );

  fifo_mw_mr #(.M(3), .N(2), .DATA_WIDTH(DW), .DEPTH(6)) u_dut_b (
    .clk(clk), .arst_n(arst_n), .full_n(full_n_b), .write(write_b), .din(din_b),
    .empty_n(empty_n_b), .read(read_b), .dout(dout_b), .count(count_b),
    .err(err_b), .err_clr(err_clr_b)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    din_a[0] = d0;
    din_a[1] = d1;
    din_a[2] = d2;
  endtask

  // Inputs are held for exactly one rising edge, then returned to idle.
  task automatic apply_stimulus(input logic [2:0] wr, input logic [1:0] rd, input logic clr);
    write_a   = wr;
    read_a    = rd;
    err_clr_a = clr;
    tick();
    write_a   = '0;
    read_a    = '0;
    err_clr_a = 1'b0;
  endtask

  initial begin
    write_a = '0; read_a = '0; din_a = '0; err_clr_a = 1'b0;
    write_b = '0; read_b = '0; din_b = '0; err_clr_b = 1'b0;

    #1 arst_n = 1'b0;
    #2;
    check_output("rst count",   count_a,   0);
    check_output("rst full_n",  full_n_a,  3'b111);
    check_output("rst empty_n", empty_n_a, 2'b00);
    check_output("rst dout0",   dout_a[0], 0);
    check_output("rst dout1",   dout_a[1], 0);
    check_output("rst err",     err_a,     0);

    @(negedge clk) arst_n = 1'b1;
    tick();
    tick();
    check_output("idle count",   count_a,   0);
    check_output("idle full_n",  full_n_a,  3'b111);
    check_output("idle empty_n", empty_n_a, 2'b00);

    set_din(32'hA, 32'hB, 32'hC);
    apply_stimulus(3'b111, 2'b00, 1'b0);
    check_output("w3 count",   count_a,   3);
    check_output("w3 dout0",   dout_a[0], 32'hA);
    check_output("w3 dout1",   dout_a[1], 32'hB);
    check_output("w3 empty_n", empty_n_a, 2'b11);

    apply_stimulus(3'b000, 2'b11, 1'b0);
    check_output("r2 dout0",   dout_a[0], 32'hC);
    check_output("r2 dout1",   dout_a[1], 0);
    check_output("r2 empty_n", empty_n_a, 2'b01);
    check_output("r2 count",   count_a,   1);

    set_din(32'h10, 32'h11, 32'h12);
    apply_stimulus(3'b111, 2'b00, 1'b0);
    set_din(32'h13, 32'h14, 32'h15);
    apply_stimulus(3'b111, 2'b00, 1'b0);
    check_output("fill7 count",  count_a,  7);
    check_output("fill7 full_n", full_n_a, 3'b001);

    set_din(32'h16, 32'h17, 32'h18);
    apply_stimulus(3'b111, 2'b00, 1'b0);
    check_output("full count",  count_a,   8);
    check_output("full full_n", full_n_a,  3'b000);
    check_output("full err",    err_a,     3'b001);
    check_output("full dout0",  dout_a[0], 32'hC);
    check_output("full dout1",  dout_a[1], 32'h10);

    apply_stimulus(3'b000, 2'b00, 1'b1);
    check_output("clr err", err_a, 3'b000);

    set_din(32'h20, 32'h21, 32'h22);
    apply_stimulus(3'b111, 2'b11, 1'b0);
    check_output("pp count",  count_a,   6);
    check_output("pp full_n", full_n_a,  3'b011);
    check_output("pp err",    err_a,     3'b001);
    check_output("pp dout0",  dout_a[0], 32'h11);
    check_output("pp dout1",  dout_a[1], 32'h12);

    apply_stimulus(3'b000, 2'b00, 1'b1);
    apply_stimulus(3'b000, 2'b11, 1'b0);
    check_output("drain1 dout0", dout_a[0], 32'h13);
    apply_stimulus(3'b000, 2'b11, 1'b0);
    check_output("drain2 count", count_a,   2);
    check_output("drain2 dout0", dout_a[0], 32'h15);
    check_output("drain2 dout1", dout_a[1], 32'h16);

    apply_stimulus(3'b000, 2'b10, 1'b0);
    check_output("nonprefix count", count_a,   2);
    check_output("nonprefix err",   err_a,     3'b100);
    check_output("nonprefix dout0", dout_a[0], 32'h15);

    apply_stimulus(3'b000, 2'b10, 1'b1);
    check_output("clr+viol err", err_a, 3'b100);
    apply_stimulus(3'b000, 2'b00, 1'b1);
    check_output("clr2 err", err_a, 3'b000);

    apply_stimulus(3'b000, 2'b01, 1'b0);
    check_output("pop1 count",   count_a,   1);
    check_output("pop1 dout0",   dout_a[0], 32'h16);
    check_output("pop1 empty_n", empty_n_a, 2'b01);

    apply_stimulus(3'b000, 2'b11, 1'b0);
    check_output("under count",   count_a,   0);
    check_output("under err",      err_a,     3'b010);
    check_output("under empty_n",  empty_n_a, 2'b00);
    check_output("under dout0",    dout_a[0], 0);

    set_din(32'h31, 32'h32, 32'h33);
    apply_stimulus(3'b111, 2'b00, 1'b0);
    check_output("pre-rst count", count_a, 3);
    #2 arst_n = 1'b0;
    #1;
    check_output("arst count",   count_a,   0);
    check_output("arst empty_n", empty_n_a, 2'b00);
    check_output("arst dout0",   dout_a[0], 0);
    check_output("arst full_n",  full_n_a,  3'b111);
    check_output("arst err",     err_a,     3'b000);
    @(negedge clk) arst_n = 1'b1;
    tick();

    // Single-word streaming through the DEPTH=6 instance wraps both pointers three times.
    for (int k = 0; k <= 20; k++) begin
      write_b[0] = (k < 20);
      din_b[0]   = 32'h100 + k;
      read_b[0]  = empty_n_b[0];
      if (empty_n_b[0]) begin
        check_output("wrap dout0", dout_b[0], 32'h100 + rd_idx);
        rd_idx++;
      end
      tick();
    end
    write_b = '0;
    read_b  = '0;
    check_output("wrap reads",   rd_idx,    20);
    check_output("wrap count",   count_b,   0);
    check_output("wrap empty_n", empty_n_b, 2'b00);
    check_output("wrap err",     err_b,     3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
